// File: rtl/trace_reg_arbiter_if.sv
// Purpose: bundles the host register bus, local requester ports and register-file port of trace_reg_arbiter.
// Latency: none, signal container only.
// Backpressure: host is retry-based (no stall), locals hold loc_req until loc_gnt, the register file never stalls.
//
// Ports (signal groups):
//   host_*  host register bus: address/write attempt in, read data and its completion strobe out
//   loc_*   N_LOCAL trace-engine requesters, flattened per-requester fields, shared read-data bus
//   mem_*   single fixed-latency register-file port
// Modports: master = environment (host, requesters, register file), slave = the arbiter.
interface trace_reg_arbiter_if #(
    parameter int N_LOCAL = 2,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 32
);
    logic [ADDR_W-1:0]         host_addr;
    logic                      host_addr_vld;
    logic [DATA_W-1:0]         host_wdata;
    logic                      host_wr_vld;
    logic [DATA_W-1:0]         host_rdata;
    logic                      host_rdata_vld;

    logic [N_LOCAL-1:0]        loc_req;
    logic [N_LOCAL-1:0]        loc_we;
    logic [N_LOCAL*ADDR_W-1:0] loc_addr;
    logic [N_LOCAL*DATA_W-1:0] loc_wdata;
    logic [N_LOCAL-1:0]        loc_gnt;
    logic [N_LOCAL-1:0]        loc_rvalid;
    logic [DATA_W-1:0]         loc_rdata;

    logic                      mem_en;
    logic                      mem_we;
    logic [ADDR_W-1:0]         mem_addr;
    logic [DATA_W-1:0]         mem_wdata;
    logic [DATA_W-1:0]         mem_rdata;

    modport master (
        output host_addr, host_addr_vld, host_wdata, host_wr_vld,
        input  host_rdata, host_rdata_vld,
        output loc_req, loc_we, loc_addr, loc_wdata,
        input  loc_gnt, loc_rvalid, loc_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );

    modport slave (
        input  host_addr, host_addr_vld, host_wdata, host_wr_vld,
        output host_rdata, host_rdata_vld,
        input  loc_req, loc_we, loc_addr, loc_wdata,
        output loc_gnt, loc_rvalid, loc_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );
endinterface

// File: rtl/trace_reg_arbiter.sv
// Purpose: shares one fixed-latency register-file port between the retry-based host bus and N_LOCAL trace requesters.
// Latency: writes and grants are zero-cycle; local read data RD_LAT cycles after grant; host read answered on the retry after fill.
// Backpressure: host is never stalled (retries until host_rdata_vld); locals wait on loc_req until loc_gnt.
//
// Ports:
//   S_AXI_ACLK    clock
//   S_AXI_ARESET  synchronous active-high reset; all outputs forced low while asserted
//   arb_bus       trace_reg_arbiter_if.slave (host_*, loc_*, mem_* groups)
module trace_reg_arbiter #(
    parameter int N_LOCAL = 2,
    parameter int ADDR_W  = 14,
    parameter int DATA_W  = 32,
    parameter int RD_LAT  = 2
) (
    input  logic               S_AXI_ACLK,
    input  logic               S_AXI_ARESET,
    trace_reg_arbiter_if.slave arb_bus
);
    localparam int IDX_W = (N_LOCAL > 1) ? $clog2(N_LOCAL) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_HELD
    } host_st_e;

    // Owner of a read in flight; travels alongside the register-file latency.
    typedef struct packed {
        logic             vld;
        logic             host;
        logic [IDX_W-1:0] idx;
    } rd_tag_t;

    host_st_e          state_q, state_d;
    logic [ADDR_W-1:0] hold_addr_q, hold_addr_d;
    logic [DATA_W-1:0] hold_data_q, hold_data_d;
    logic              stale_q, stale_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic [IDX_W-1:0]  rr_ptr_q, rr_ptr_d;
    rd_tag_t           tag_q [RD_LAT];
    rd_tag_t           tag_d [RD_LAT];
    rd_tag_t           new_tag;
    rd_tag_t           tag_exit;

    logic              run;
    logic              host_wr;
    logic              host_rd_att;
    logic              host_rd_issue;
    logic              host_fill;
    logic              wr_hit;
    logic              win_vld;
    logic [IDX_W-1:0]  win_idx;
    logic [IDX_W:0]    cand;

    logic              mem_en_c;
    logic              mem_we_c;
    logic [ADDR_W-1:0] mem_addr_c;
    logic [DATA_W-1:0] mem_wdata_c;
    logic [N_LOCAL-1:0] loc_gnt_c;
    logic [N_LOCAL-1:0] loc_rvalid_c;
    logic [DATA_W-1:0] loc_rdata_c;
    logic              host_rdata_vld_c;
    logic [DATA_W-1:0] host_rdata_c;

    // Nothing is issued or returned while reset is held, so every output reads 0.
    assign run           = ~S_AXI_ARESET;
    assign host_wr       = run & arb_bus.host_wr_vld;
    assign host_rd_att   = run & arb_bus.host_addr_vld & ~arb_bus.host_wr_vld;
    assign host_rd_issue = host_rd_att & (state_q == ST_IDLE);

    // Port arbitration: host write > host read issue > round-robin locals.
    always_comb begin
        mem_en_c    = 1'b0;
        mem_we_c    = 1'b0;
        mem_addr_c  = '0;
        mem_wdata_c = '0;
        loc_gnt_c   = '0;
        new_tag     = '0;
        rr_ptr_d    = rr_ptr_q;
        win_vld     = 1'b0;
        win_idx     = '0;
        cand        = '0;

        // First requesting index at or after the pointer, wrapping.
        for (int k = 0; k < N_LOCAL; k++) begin
            if (run && !win_vld) begin
                cand = {1'b0, rr_ptr_q} + (IDX_W+1)'(k);
                if (cand >= (IDX_W+1)'(N_LOCAL)) begin
                    cand = cand - (IDX_W+1)'(N_LOCAL);
                end
                if (arb_bus.loc_req[cand[IDX_W-1:0]]) begin
                    win_vld = 1'b1;
                    win_idx = cand[IDX_W-1:0];
                end
            end
        end

        if (host_wr) begin
            mem_en_c    = 1'b1;
            mem_we_c    = 1'b1;
            mem_addr_c  = arb_bus.host_addr;
            mem_wdata_c = arb_bus.host_wdata;
        end else if (host_rd_issue) begin
            mem_en_c     = 1'b1;
            mem_addr_c   = arb_bus.host_addr;
            new_tag.vld  = 1'b1;
            new_tag.host = 1'b1;
        end else if (win_vld) begin
            mem_en_c           = 1'b1;
            mem_we_c           = arb_bus.loc_we[win_idx];
            mem_addr_c         = arb_bus.loc_addr[win_idx*ADDR_W +: ADDR_W];
            mem_wdata_c        = arb_bus.loc_wdata[win_idx*DATA_W +: DATA_W];
            loc_gnt_c[win_idx] = 1'b1;
            new_tag.vld        = ~arb_bus.loc_we[win_idx];
            new_tag.idx        = win_idx;
            rr_ptr_d           = (win_idx == IDX_W'(N_LOCAL - 1)) ? '0 : win_idx + 1'b1;
        end
    end

    // Tag delay line: a tag leaves the last stage in the cycle its data is on mem_rdata.
    always_comb begin
        tag_d[0] = new_tag;
        for (int k = 1; k < RD_LAT; k++) begin
            tag_d[k] = tag_q[k-1];
        end
    end

    assign tag_exit  = tag_q[RD_LAT-1];
    assign host_fill = run & tag_exit.vld & tag_exit.host;

    always_comb begin
        loc_rvalid_c = '0;
        loc_rdata_c  = '0;
        if (run && tag_exit.vld && !tag_exit.host) begin
            loc_rvalid_c[tag_exit.idx] = 1'b1;
            loc_rdata_c                = arb_bus.mem_rdata;
        end
    end

    // Any write landing on the fetched address invalidates the hold contents.
    assign wr_hit = mem_en_c & mem_we_c & (mem_addr_c == hold_addr_q);

    // Host read FSM.
    always_comb begin
        state_d          = state_q;
        hold_addr_d      = hold_addr_q;
        hold_data_d      = hold_data_q;
        stale_d          = stale_q;
        host_rdata_d     = host_rdata_q;
        host_rdata_vld_c = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (host_rd_issue) begin
                    hold_addr_d = arb_bus.host_addr;
                    stale_d     = 1'b0;
                    state_d     = ST_WAIT;
                end
            end
            ST_WAIT: begin
                if (wr_hit) begin
                    stale_d = 1'b1;
                end
                if (host_fill) begin
                    // A write in the fill cycle counts too; drop and let the host refetch.
                    if (stale_q || wr_hit) begin
                        state_d = ST_IDLE;
                    end else begin
                        hold_data_d = arb_bus.mem_rdata;
                        state_d     = ST_HELD;
                    end
                end
            end
            ST_HELD: begin
                if (wr_hit) begin
                    state_d = ST_IDLE;
                end else if (host_rd_att) begin
                    // Matching retry completes; any other address abandons the hold.
                    if (arb_bus.host_addr == hold_addr_q) begin
                        host_rdata_vld_c = 1'b1;
                        host_rdata_d     = hold_data_q;
                    end
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign host_rdata_c = !run            ? '0 :
                          host_rdata_vld_c ? hold_data_q : host_rdata_q;

    always_ff @(posedge S_AXI_ACLK) begin
        if (S_AXI_ARESET) begin
            state_q      <= ST_IDLE;
            hold_addr_q  <= '0;
            hold_data_q  <= '0;
            stale_q      <= 1'b0;
            host_rdata_q <= '0;
            rr_ptr_q     <= '0;
            for (int k = 0; k < RD_LAT; k++) begin
                tag_q[k] <= '0;
            end
        end else begin
            state_q      <= state_d;
            hold_addr_q  <= hold_addr_d;
            hold_data_q  <= hold_data_d;
            stale_q      <= stale_d;
            host_rdata_q <= host_rdata_d;
            rr_ptr_q     <= rr_ptr_d;
            for (int k = 0; k < RD_LAT; k++) begin
                tag_q[k] <= tag_d[k];
            end
        end
    end

    assign arb_bus.mem_en         = mem_en_c;
    assign arb_bus.mem_we         = mem_we_c;
    assign arb_bus.mem_addr       = mem_addr_c;
    assign arb_bus.mem_wdata      = mem_wdata_c;
    assign arb_bus.loc_gnt        = loc_gnt_c;
    assign arb_bus.loc_rvalid     = loc_rvalid_c;
    assign arb_bus.loc_rdata      = loc_rdata_c;
    assign arb_bus.host_rdata_vld = host_rdata_vld_c;
    assign arb_bus.host_rdata     = host_rdata_c;

endmodule
